// File: rtl/shift_sched_ctrl.sv
// Round-robin scheduler sharing one one-hot spike shifter among NREQ requesters.
// Grants, converts the signed shift amount to a one-hot code and returns the tagged result.
module shift_sched_ctrl #(
    parameter int LEN           = 8,
    parameter int MAX_SHIFT_MAG = 2,
    parameter int NREQ          = 4,
    localparam int AW           = $clog2(MAX_SHIFT_MAG + 1) + 1,
    localparam int TW           = $clog2(NREQ),
    localparam int MW           = 2 * MAX_SHIFT_MAG + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*LEN-1:0]  req_ip,
    input  logic [NREQ*AW-1:0]   req_amt,
    output logic [0:LEN-1]       sh_ip,
    output logic [0:MW-1]        sh_mag,
    input  logic [0:LEN-1]       sh_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:LEN-1]       out_op,
    output logic [TW-1:0]        out_tag,
    output logic                 out_clamp
);

    localparam int IW = $clog2(MW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [TW-1:0]      rr_ptr;
    logic [TW-1:0]      tag_q;
    logic [0:LEN-1]     vol_q;
    logic [IW-1:0]      idx_q;
    logic               clamp_q;

    logic               found;
    logic [TW-1:0]      gnt;
    logic signed [AW-1:0] amt_g;
    logic [IW-1:0]      idx_d;
    logic               clamp_d;
    logic [TW-1:0]      rr_next;

    // First valid requester at or above rr_ptr, wrapping around
    always_comb begin
        int j;
        found = 1'b0;
        gnt   = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(rr_ptr) + i) % NREQ;
            if (!found && req_valid[j]) begin
                found = 1'b1;
                gnt   = TW'(j);
            end
        end
    end

    // Clamp the granted amount and map it to a one-hot index
    always_comb begin
        int a;
        int e;
        amt_g   = req_amt[gnt*AW +: AW];
        a       = int'(amt_g);
        e       = a;
        clamp_d = 1'b0;
        if (a > MAX_SHIFT_MAG) begin
            e       = MAX_SHIFT_MAG;
            clamp_d = 1'b1;
        end else if (a < -MAX_SHIFT_MAG) begin
            e       = -MAX_SHIFT_MAG;
            clamp_d = 1'b1;
        end
        idx_d = IW'(e + MAX_SHIFT_MAG);
    end

    assign rr_next = (tag_q == TW'(NREQ - 1)) ? '0 : tag_q + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: grant strobe in IDLE, shift code only in EXEC
    always_comb begin
        req_ready = '0;
        sh_mag    = '0;
        if (state == IDLE && found) req_ready[gnt] = 1'b1;
        if (state == EXEC)          sh_mag[idx_q]  = 1'b1;
    end

    assign sh_ip = vol_q;

    // Payload capture at grant, result capture in EXEC, pointer advance on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            tag_q     <= '0;
            vol_q     <= '0;
            idx_q     <= '0;
            clamp_q   <= 1'b0;
            out_valid <= 1'b0;
            out_op    <= '0;
            out_tag   <= '0;
            out_clamp <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        vol_q   <= req_ip[gnt*LEN +: LEN];
                        idx_q   <= idx_d;
                        clamp_q <= clamp_d;
                        tag_q   <= gnt;
                    end
                end
                EXEC: begin
                    out_op    <= sh_op;
                    out_tag   <= tag_q;
                    out_clamp <= clamp_q;
                    out_valid <= 1'b1;
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        rr_ptr    <= rr_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sched_ctrl.sv
// Bench for shift_sched_ctrl with a behavioural rotating shifter and
// a round-robin reference model.
module tb_shift_sched_ctrl;

    localparam int LEN  = 8;
    localparam int M    = 2;
    localparam int NREQ = 4;
    localparam int AW   = $clog2(M + 1) + 1;
    localparam int TW   = $clog2(NREQ);
    localparam int MW   = 2 * M + 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*LEN-1:0] req_ip = '0;
    logic [NREQ*AW-1:0]  req_amt = '0;
    logic [0:LEN-1]      sh_ip;
    logic [0:MW-1]       sh_mag;
    logic [0:LEN-1]      sh_op;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [0:LEN-1]      out_op;
    logic [TW-1:0]       out_tag;
    logic                out_clamp;

    int nchk = 0;
    int nerr = 0;
    int model_rr = 0;

    shift_sched_ctrl #(.LEN(LEN), .MAX_SHIFT_MAG(M), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ip(req_ip), .req_amt(req_amt),
        .sh_ip(sh_ip), .sh_mag(sh_mag), .sh_op(sh_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_tag(out_tag), .out_clamp(out_clamp)
    );

    always #5 clk = ~clk;

    // Rotating shifter: spike at time i moves to time i+s (mod LEN)
    function automatic logic [0:LEN-1] rot(input logic [0:LEN-1] v, input int s);
        logic [0:LEN-1] r;
        r = '0;
        for (int i = 0; i < LEN; i++)
            if (v[i]) r[(i + s + LEN) % LEN] = 1'b1;
        return r;
    endfunction

    always_comb begin
        int s;
        s = 0;
        for (int i = 0; i < MW; i++)
            if (sh_mag[i]) s = i - M;
        sh_op = rot(sh_ip, s);
    end

    function automatic int clamp_amt(input logic [AW-1:0] amt);
        int a;
        a = int'($signed(amt));
        if (a > M)  return M;
        if (a < -M) return -M;
        return a;
    endfunction

    function automatic logic [NREQ-1:0] bit_of(input int k);
        logic [NREQ-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (3) tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            nchk++;
            if ({req_ready, sh_ip, sh_mag, out_valid, out_op, out_tag, out_clamp} !== '0) begin
                nerr++;
                $display("FAIL reset_idle cyc%0d: ready=%b ip=%b mag=%b ov=%b op=%b tag=%0d cl=%b, required all 0",
                         c, req_ready, sh_ip, sh_mag, out_valid, out_op, out_tag, out_clamp);
            end
            tick();
        end
        model_rr = 0;
    endtask

    task automatic test_single(input int k, input logic [0:LEN-1] ip, input logic [AW-1:0] amt);
        int e;
        int w;
        logic cl;
        logic [0:MW-1] code;
        logic [0:LEN-1] op;
        e = clamp_amt(amt);
        cl = (e != int'($signed(amt)));
        code = '0;
        code[e + M] = 1'b1;
        op = rot(ip, e);
        req_valid = bit_of(k);
        req_ip[k*LEN +: LEN] = ip;
        req_amt[k*AW +: AW] = amt;
        out_ready = 1'b1;
        @(negedge clk);
        w = 0;
        while (req_ready == '0 && w < 8) begin
            tick();
            @(negedge clk);
            w++;
        end
        nchk++;
        if (req_ready !== bit_of(k)) begin
            nerr++;
            $display("FAIL single_grant k=%0d: ready=%b, required %b", k, req_ready, bit_of(k));
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        nchk++;
        if (sh_mag !== code || sh_ip !== ip || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL single_exec k=%0d: mag=%b ip=%b ov=%b, required mag=%b ip=%b ov=0",
                     k, sh_mag, sh_ip, out_valid, code, ip);
        end
        tick();
        @(negedge clk);
        nchk++;
        if (out_valid !== 1'b1 || out_tag !== TW'(k) || out_op !== op ||
            out_clamp !== cl || sh_mag !== '0) begin
            nerr++;
            $display("FAIL single_resp k=%0d amt=%0d: ov=%b tag=%0d op=%b cl=%b mag=%b, required ov=1 tag=%0d op=%b cl=%b mag=0",
                     k, $signed(amt), out_valid, out_tag, out_op, out_clamp, sh_mag, k, op, cl);
        end
        tick();
        @(negedge clk);
        nchk++;
        if (out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL single_done k=%0d: ov=%b, required 0", k, out_valid);
        end
        model_rr = (k + 1) % NREQ;
        tick();
    endtask

    task automatic test_random_singles(input int n);
        for (int i = 0; i < n; i++)
            test_single(int'($urandom_range(0, NREQ - 1)), LEN'($urandom), AW'($urandom));
    endtask

    task automatic test_all_valid();
        logic [0:LEN-1] ips [NREQ];
        logic [AW-1:0]  amts [NREQ];
        logic [0:LEN-1] pend_op;
        int pend_tag;
        int exp;
        int last;
        int ngr;
        for (int k = 0; k < NREQ; k++) begin
            ips[k] = LEN'($urandom);
            amts[k] = AW'($urandom);
            req_ip[k*LEN +: LEN] = ips[k];
            req_amt[k*AW +: AW] = amts[k];
        end
        pend_op = '0;
        pend_tag = 0;
        exp = model_rr;
        last = 0;
        ngr = 0;
        out_ready = 1'b1;
        req_valid = '1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            nchk++;
            if (!$onehot0(req_ready)) begin
                nerr++;
                $display("FAIL rr_onehot cyc%0d: ready=%b, required at most one bit", c, req_ready);
            end
            if (req_ready != '0) begin
                nchk++;
                if (req_ready !== bit_of(exp) || (ngr > 0 && c - last != 3)) begin
                    nerr++;
                    $display("FAIL rr_grant cyc%0d: ready=%b gap=%0d, required %b gap=3",
                             c, req_ready, c - last, bit_of(exp));
                end
                pend_tag = exp;
                pend_op = rot(ips[exp], clamp_amt(amts[exp]));
                last = c;
                ngr++;
                exp = (exp + 1) % NREQ;
            end
            if (out_valid) begin
                nchk++;
                if (out_tag !== TW'(pend_tag) || out_op !== pend_op) begin
                    nerr++;
                    $display("FAIL rr_result cyc%0d: tag=%0d op=%b, required tag=%0d op=%b",
                             c, out_tag, out_op, pend_tag, pend_op);
                end
            end
            tick();
            if (c == 14) req_valid = '0;
        end
        nchk++;
        if (ngr != 5) begin
            nerr++;
            $display("FAIL rr_count: grants=%0d, required 5", ngr);
        end
        model_rr = exp;
        repeat (2) tick();
    endtask

    task automatic test_backpressure();
        int k0;
        logic [0:LEN-1] ip;
        logic [AW-1:0] amt;
        logic [0:LEN-1] op;
        k0 = model_rr;
        ip = LEN'($urandom) | LEN'(1);
        amt = AW'($urandom);
        op = rot(ip, clamp_amt(amt));
        for (int k = 0; k < NREQ; k++) begin
            req_ip[k*LEN +: LEN] = (k == k0) ? ip : LEN'($urandom);
            req_amt[k*AW +: AW] = (k == k0) ? amt : AW'($urandom);
        end
        out_ready = 1'b0;
        req_valid = '1;
        @(negedge clk);
        nchk++;
        if (req_ready !== bit_of(k0)) begin
            nerr++;
            $display("FAIL bp_grant: ready=%b, required %b", req_ready, bit_of(k0));
        end
        tick();
        tick();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            nchk++;
            if (out_valid !== 1'b1 || out_tag !== TW'(k0) || out_op !== op || req_ready !== '0) begin
                nerr++;
                $display("FAIL bp_hold cyc%0d: ov=%b tag=%0d op=%b ready=%b, required ov=1 tag=%0d op=%b ready=0",
                         c, out_valid, out_tag, out_op, req_ready, k0, op);
            end
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        nchk++;
        if (out_valid !== 1'b1 || out_op !== op) begin
            nerr++;
            $display("FAIL bp_release: ov=%b op=%b, required ov=1 op=%b", out_valid, out_op, op);
        end
        tick();
        @(negedge clk);
        nchk++;
        if (out_valid !== 1'b0 || req_ready !== bit_of((k0 + 1) % NREQ)) begin
            nerr++;
            $display("FAIL bp_next: ov=%b ready=%b, required ov=0 ready=%b",
                     out_valid, req_ready, bit_of((k0 + 1) % NREQ));
        end
        tick();
        req_valid = '0;
        repeat (3) tick();
        model_rr = (k0 + 2) % NREQ;
    endtask

    task automatic test_reset_exec();
        test_single(1, 8'b0100_0000, 3'sd1);
        req_ip[2*LEN +: LEN] = 8'b0001_0000;
        req_amt[2*AW +: AW] = 3'sd2;
        req_valid = 4'b0100;
        @(negedge clk);
        nchk++;
        if (req_ready !== 4'b0100) begin
            nerr++;
            $display("FAIL rx_grant: ready=%b, required 0100", req_ready);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        nchk++;
        if (sh_mag === '0) begin
            nerr++;
            $display("FAIL rx_exec: mag=%b, required nonzero", sh_mag);
        end
        rst = 1'b1;
        tick();
        @(negedge clk);
        nchk++;
        if (out_valid !== 1'b0 || sh_mag !== '0) begin
            nerr++;
            $display("FAIL rx_discard: ov=%b mag=%b, required ov=0 mag=0", out_valid, sh_mag);
        end
        tick();
        rst = 1'b0;
        req_valid = '1;
        @(negedge clk);
        nchk++;
        if (req_ready !== 4'b0001 || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL rx_first: ready=%b ov=%b, required ready=0001 ov=0", req_ready, out_valid);
        end
        tick();
        req_valid = '0;
        repeat (3) tick();
        model_rr = 1;
    endtask

    initial begin
        test_reset();
        test_single(0, 8'b0001_0000, 3'sd1);
        test_single(1, 8'b1000_0001, 3'b101);
        test_single(2, 8'b0110_0000, 3'sd3);
        test_single(3, 8'b0000_0000, 3'sd0);
        test_single(0, 8'b0010_0100, 3'b100);
        test_random_singles(16);
        test_all_valid();
        test_backpressure();
        test_all_valid();
        test_reset_exec();
        test_all_valid();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary, required completion");
        $fatal(1);
    end

endmodule
